// File: rtl/prio_encoder_pipe.sv
// Registered N-input priority encoder with a one-entry valid/ready output buffer.
// Define PRIO_ENC_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module prio_encoder_pipe #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [N-1:0] in,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out,
    output logic         valid,
    output logic         multi
);

    logic         r_out_vld;
    logic [W-1:0] r_out;
    logic         r_valid;
    logic         r_multi;

    logic         w_cap;
    logic         w_any;
    logic         w_multi;
    logic [N-1:0] w_search;
    logic [W-1:0] w_off;
    logic [W-1:0] w_idx;

    assign in_rdy  = !r_out_vld || out_rdy;
    assign w_cap   = in_vld && in_rdy;
    assign w_any   = |in;
    // clearing the lowest set bit leaves something only if two or more bits were set
    assign w_multi = |(in & (in - N'(1)));

    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_search[i]) begin
                w_off = W'(i);
            end
        end
    end

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [W-1:0]   r_rr_ptr;
    logic [2*N-1:0] w_dbl;
    logic [W:0]     w_sum;

    // rotate so bit rr_ptr lands at position 0, then map the offset back modulo N
    assign w_dbl    = {in, in} >> r_rr_ptr;
    assign w_search = w_dbl[N-1:0];
    assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};

    always_comb begin
        w_idx = w_sum[W-1:0];
        if (w_sum >= (W+1)'(N)) begin
            w_idx = W'(w_sum - (W+1)'(N));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_cap && w_any) begin
            r_rr_ptr <= (w_idx == W'(N - 1)) ? '0 : w_idx + W'(1);
        end
    end
`else
    assign w_search = in;
    assign w_idx    = w_off;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_multi   <= 1'b0;
        end else begin
            if (w_cap) begin
                r_out_vld <= 1'b1;
                r_out     <= w_any ? w_idx : '0;
                r_valid   <= w_any;
                r_multi   <= w_multi;
            end else if (out_rdy) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign out_vld = r_out_vld;
    assign out     = r_out;
    assign valid   = r_valid;
    assign multi   = r_multi;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Scoreboard bench for prio_encoder_pipe (N=8); a monitor checks every accepted result.
module tb_prio_encoder_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] in_v;
    logic       out_vld;
    logic       out_rdy;
    logic [2:0] out_v;
    logic       valid;
    logic       multi;

    typedef struct packed {
        logic [2:0] o;
        logic       v;
        logic       m;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_pass;

    prio_encoder_pipe #(.N(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (in_vld),
        .in_rdy (in_rdy),
        .in     (in_v),
        .out_vld(out_vld),
        .out_rdy(out_rdy),
        .out    (out_v),
        .valid  (valid),
        .multi  (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // handshake completes at the coming edge; compare the result then leaving
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            if (sb.size() == 0) begin
                chk("mon_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_out",   32'(out_v), 32'(e.o));
                chk("mon_valid", 32'(valid), 32'(e.v));
                chk("mon_multi", 32'(multi), 32'(e.m));
            end
        end
    end

    task automatic send(input logic [7:0] v, input logic [2:0] eo, input logic ev, input logic em);
        int  t;
        bit  done;
        t    = 0;
        done = 1'b0;
        in_vld = 1'b1;
        in_v   = v;
        while (!done && t < 50) begin
            done = in_rdy;
            if (done) sb.push_back('{eo, ev, em});
            @(posedge clk);
            #1;
            t++;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_vld = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_v    = 8'h00;
        out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out",     32'(out_v),   32'd0);
        chk("rst_valid",   32'(valid),   32'd0);
        chk("rst_multi",   32'(multi),   32'd0);
        chk("rst_in_rdy",  32'(in_rdy),  32'd1);

        // zero vector then one-hot sweep, streamed back to back
        send(8'h00, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(8'(1 << i), 3'(i), 1'b1, 1'b0);
        end
        idle(2);
        chk("pop_hold_out_vld", 32'(out_vld), 32'd0);
        chk("pop_hold_out",     32'(out_v),   32'd7);
        chk("pop_hold_valid",   32'(valid),   32'd1);

        // back-pressure: 8'h10 held while 8'h02 waits
        out_rdy = 1'b0;
        send(8'h10, 3'd4, 1'b1, 1'b0);
        in_vld = 1'b1;
        in_v   = 8'h02;
        for (int c = 0; c < 3; c++) begin
            chk("bp_in_rdy",  32'(in_rdy),  32'd0);
            chk("bp_out_vld", 32'(out_vld), 32'd1);
            chk("bp_out",     32'(out_v),   32'd4);
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        #1;
        chk("bp_release_in_rdy", 32'(in_rdy), 32'd1);
        sb.push_back('{3'd1, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        chk("bp_swap_out_vld", 32'(out_vld), 32'd1);
        chk("bp_swap_out",     32'(out_v),   32'd1);
        idle(2);

        // reset while a result is held under back-pressure
        out_rdy = 1'b0;
        send(8'h08, 3'd3, 1'b1, 1'b0);
        in_vld = 1'b0;
        chk("pre_rst_out_vld", 32'(out_vld), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        chk("mid_rst_out_vld", 32'(out_vld), 32'd0);
        chk("mid_rst_out",     32'(out_v),   32'd0);
        chk("mid_rst_valid",   32'(valid),   32'd0);
        chk("mid_rst_multi",   32'(multi),   32'd0);
        chk("mid_rst_in_rdy",  32'(in_rdy),  32'd1);
        out_rdy = 1'b1;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
        for (int i = 0; i < 9; i++) begin
            send(8'hFF, 3'(i % 8), 1'b1, 1'b1);
        end
        send(8'h81, 3'd7, 1'b1, 1'b1);
        send(8'h81, 3'd0, 1'b1, 1'b1);
`else
        send(8'hA4, 3'd2, 1'b1, 1'b1);
        send(8'hFF, 3'd0, 1'b1, 1'b1);
        send(8'h80, 3'd7, 1'b1, 1'b0);
        send(8'hC0, 3'd6, 1'b1, 1'b1);
        send(8'h03, 3'd0, 1'b1, 1'b1);
`endif
        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
